// File: rtl/bcd_timer_ctrl.sv
// Programmable up/down BCD timer controller: prescaler, run/pause/done FSM,
// preset loading with per-digit saturation, and terminal-count detection.

module bcd_digit (
  input  logic       dn,
  input  logic       cin,
  input  logic [3:0] raw,
  input  logic [3:0] d,
  output logic [3:0] sat,
  output logic [3:0] nxt
);
  always_comb begin
    sat = (raw > 4'd9) ? 4'd9 : raw;
    nxt = d;
    if (cin) begin
      if (!dn) nxt = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      else     nxt = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  end
endmodule

module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                mode,
  output logic [4*DIGITS-1:0] count,
  output logic                tick_en,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3} st_t;

  st_t           cur_st, nxt_st;
  logic [W-1:0]  count_r, count_n;
  logic [W-1:0]  target, target_n;
  logic          mode_r, mode_n;
  logic [PW-1:0] presc, presc_n;
  logic          done_r, done_n;
  logic          busy_r, busy_n;

  logic [DIGITS-1:0][3:0] sat_v, step_v;
  logic [DIGITS-1:0]      carry;
  logic [W-1:0]           sat_w, step_w, endpoint, reload;

  // Ripple carry/borrow chain: digit i steps only when all lower digits wrap.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .dn  (mode_r),
      .cin (carry[i]),
      .raw (load_val[4*i +: 4]),
      .d   (count_r[4*i +: 4]),
      .sat (sat_v[i]),
      .nxt (step_v[i])
    );
    if (i < DIGITS - 1) begin : g_c
      assign carry[i+1] = carry[i] &
        (mode_r ? (count_r[4*i +: 4] == 4'd0) : (count_r[4*i +: 4] >= 4'd9));
    end
  end

  assign sat_w    = sat_v;
  assign step_w   = step_v;
  assign endpoint = mode_r ? '0 : target;
  assign reload   = mode_r ? target : '0;

  assign tick_en = (cur_st == S_RUN) && (presc == PMAX);
  assign count   = count_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign state   = cur_st;

  always_comb begin
    nxt_st   = cur_st;
    count_n  = count_r;
    presc_n  = presc;
    target_n = target;
    mode_n   = mode_r;
    done_n   = 1'b0;
    if (clear) begin
      nxt_st  = S_IDLE;
      count_n = '0;
      presc_n = '0;
    end else if (load && (cur_st == S_IDLE || cur_st == S_DONE)) begin
      nxt_st   = S_IDLE;
      mode_n   = mode;
      target_n = sat_w;
      count_n  = mode ? sat_w : '0;
      presc_n  = '0;
    end else begin
      // An ignored load falls through; stop outranks start in every state.
      unique case (cur_st)
        S_IDLE: begin
          if (!stop && start) begin
            if (count_r == endpoint) begin
              nxt_st = S_DONE;
              done_n = 1'b1;
            end else begin
              nxt_st  = S_RUN;
              presc_n = '0;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            nxt_st = S_PAUSE;
          end else if (presc == PMAX) begin
            presc_n = '0;
            count_n = step_w;
            if (step_w == endpoint) begin
              nxt_st = S_DONE;
              done_n = 1'b1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (stop) begin
            nxt_st  = S_IDLE;
            presc_n = '0;
          end else if (start) begin
            nxt_st = S_RUN;
          end
        end
        S_DONE: begin
          if (!stop && start) begin
            count_n = reload;
            presc_n = '0;
            if (target == '0) begin
              nxt_st = S_DONE;
              done_n = 1'b1;
            end else begin
              nxt_st = S_RUN;
            end
          end
        end
        default: nxt_st = S_IDLE;
      endcase
    end
    busy_n = (nxt_st == S_RUN) || (nxt_st == S_PAUSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st  <= S_IDLE;
      count_r <= '0;
      target  <= '0;
      mode_r  <= 1'b0;
      presc   <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      count_r <= count_n;
      target  <= target_n;
      mode_r  <= mode_n;
      presc   <= presc_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
    end
  end
endmodule
